// File: rtl/ex_md_if.sv
// rtl/ex_md_if.sv - execute-stage bus between ID/EX and EX/MEM
interface ex_md_if #(
  parameter int DATA_W = 32
);
  logic [7:0]        aluop_i;
  logic [2:0]        alusel_i;
  logic [DATA_W-1:0] reg1_i;
  logic [DATA_W-1:0] reg2_i;
  logic [4:0]        wd_i;
  logic              wreg_i;
  logic [DATA_W-1:0] hi_i;
  logic [DATA_W-1:0] lo_i;
  logic              flush_i;
  logic [4:0]        wd_o;
  logic              wreg_o;
  logic [DATA_W-1:0] wdata_o;
  logic              whilo_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic              stallreq_o;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i, flush_i,
    input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, hi_i, lo_i, flush_i,
    output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );
endinterface

// File: rtl/ex_md.sv
// rtl/ex_md.sv - MIPS32 execute stage with multiply and iterative divide
module ex_md #(
  parameter int DATA_W = 32
) (
  input logic   clk,
  input logic   rst,
  ex_md_if.slave ex
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int SH_W  = $clog2(DATA_W);

  localparam logic [7:0] OP_AND   = 8'h24, OP_OR   = 8'h25, OP_XOR  = 8'h26, OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL   = 8'h7c, OP_SRL  = 8'h02, OP_SRA  = 8'h03;
  localparam logic [7:0] OP_SLT   = 8'h2a, OP_SLTU = 8'h2b, OP_ADDU = 8'h21, OP_SUBU = 8'h23;
  localparam logic [7:0] OP_MULT  = 8'h18, OP_MULTU = 8'h19, OP_DIV = 8'h1a, OP_DIVU = 8'h1b;
  localparam logic [7:0] OP_MFHI  = 8'h10, OP_MTHI = 8'h11, OP_MFLO = 8'h12, OP_MTLO = 8'h13;

  localparam logic [2:0] SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010, SEL_MOVE = 3'b011;
  localparam logic [2:0] SEL_ARITH = 3'b100, SEL_MUL   = 3'b101;

  typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} div_state_t;

  div_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

  logic [DATA_W-1:0]   logic_res, shift_res, arith_res, move_res, mul_res, sel_res;
  logic [2*DATA_W-1:0] prod_s, prod_u;
  logic [SH_W-1:0]     sh;
  logic [DATA_W:0]     trial;
  logic                is_div, is_sdiv;

  assign sh      = ex.reg1_i[SH_W-1:0];
  assign is_sdiv = (ex.aluop_i == OP_DIV);
  assign is_div  = is_sdiv || (ex.aluop_i == OP_DIVU);
  // Dividend bit enters the partial remainder; a borrow in the top bit means the divisor did not fit.
  assign trial   = {rem_q, quo_q[DATA_W-1]} - {1'b0, dvs_q};

  // Single-cycle datapath: every result class is evaluated, alusel_i picks one.
  always_comb begin
    logic_res = '0;
    shift_res = '0;
    arith_res = '0;
    move_res  = '0;
    mul_res   = '0;
    prod_s    = {{DATA_W{ex.reg1_i[DATA_W-1]}}, ex.reg1_i} * {{DATA_W{ex.reg2_i[DATA_W-1]}}, ex.reg2_i};
    prod_u    = {{DATA_W{1'b0}}, ex.reg1_i} * {{DATA_W{1'b0}}, ex.reg2_i};
    case (ex.aluop_i)
      OP_AND:   logic_res = ex.reg1_i & ex.reg2_i;
      OP_OR:    logic_res = ex.reg1_i | ex.reg2_i;
      OP_XOR:   logic_res = ex.reg1_i ^ ex.reg2_i;
      OP_NOR:   logic_res = ~(ex.reg1_i | ex.reg2_i);
      OP_SLL:   shift_res = ex.reg2_i << sh;
      OP_SRL:   shift_res = ex.reg2_i >> sh;
      OP_SRA:   shift_res = $signed(ex.reg2_i) >>> sh;
      OP_ADDU:  arith_res = ex.reg1_i + ex.reg2_i;
      OP_SUBU:  arith_res = ex.reg1_i - ex.reg2_i;
      OP_SLT:   arith_res = {{(DATA_W-1){1'b0}}, ($signed(ex.reg1_i) < $signed(ex.reg2_i))};
      OP_SLTU:  arith_res = {{(DATA_W-1){1'b0}}, (ex.reg1_i < ex.reg2_i)};
      OP_MFHI:  move_res  = ex.hi_i;
      OP_MFLO:  move_res  = ex.lo_i;
      OP_MULT:  mul_res   = prod_s[DATA_W-1:0];
      OP_MULTU: mul_res   = prod_u[DATA_W-1:0];
      default:  ;
    endcase
    case (ex.alusel_i)
      SEL_LOGIC: sel_res = logic_res;
      SEL_SHIFT: sel_res = shift_res;
      SEL_ARITH: sel_res = arith_res;
      SEL_MOVE:  sel_res = move_res;
      SEL_MUL:   sel_res = mul_res;
      default:   sel_res = '0;
    endcase
  end

  // Divider next-state: latch magnitudes in IDLE, one restoring step per BUSY cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      IDLE: begin
        if (is_div) begin
          cnt_d     = '0;
          rem_d     = '0;
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
          if (ex.reg2_i == '0) begin
            state_d = DIVZERO;
            quo_d   = '0;
            dvs_d   = '0;
          end else begin
            state_d = BUSY;
            quo_d   = ex.reg1_i;
            dvs_d   = ex.reg2_i;
            if (is_sdiv) begin
              quo_d     = ex.reg1_i[DATA_W-1] ? -ex.reg1_i : ex.reg1_i;
              dvs_d     = ex.reg2_i[DATA_W-1] ? -ex.reg2_i : ex.reg2_i;
              neg_quo_d = ex.reg1_i[DATA_W-1] ^ ex.reg2_i[DATA_W-1];
              neg_rem_d = ex.reg1_i[DATA_W-1];
            end
          end
        end
      end
      DIVZERO: begin
        quo_d   = '0;
        rem_d   = '0;
        state_d = DONE;
      end
      BUSY: begin
        if (!trial[DATA_W]) begin
          rem_d = trial[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
          quo_d = {quo_q[DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (ex.flush_i) state_d = IDLE;
  end

  // Divider state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Output drive: HI/LO requests, stall, and the flush/reset overrides.
  always_comb begin
    ex.wd_o       = ex.wd_i;
    ex.wreg_o     = ex.wreg_i;
    ex.wdata_o    = sel_res;
    ex.whilo_o    = 1'b0;
    ex.hi_o       = ex.hi_i;
    ex.lo_o       = ex.lo_i;
    ex.stallreq_o = 1'b0;
    case (ex.aluop_i)
      OP_MTHI: begin
        ex.whilo_o = 1'b1;
        ex.hi_o    = ex.reg1_i;
      end
      OP_MTLO: begin
        ex.whilo_o = 1'b1;
        ex.lo_o    = ex.reg1_i;
      end
      OP_MULT: begin
        ex.whilo_o = 1'b1;
        {ex.hi_o, ex.lo_o} = prod_s;
      end
      OP_MULTU: begin
        ex.whilo_o = 1'b1;
        {ex.hi_o, ex.lo_o} = prod_u;
      end
      OP_DIV, OP_DIVU: begin
        if (state_q == DONE) begin
          ex.whilo_o = 1'b1;
          ex.lo_o    = neg_quo_q ? -quo_q : quo_q;
          ex.hi_o    = neg_rem_q ? -rem_q : rem_q;
        end else begin
          ex.stallreq_o = 1'b1;
        end
      end
      default: ;
    endcase
    if (ex.flush_i) begin
      ex.whilo_o    = 1'b0;
      ex.stallreq_o = 1'b0;
    end
    if (rst) begin
      ex.wd_o       = '0;
      ex.wreg_o     = 1'b0;
      ex.wdata_o    = '0;
      ex.whilo_o    = 1'b0;
      ex.hi_o       = '0;
      ex.lo_o       = '0;
      ex.stallreq_o = 1'b0;
    end
  end
endmodule

// File: doc/ex_md.md
# ex_md

Parametrised execute stage for the MIPS32 core. It sits between the ID/EX and EX/MEM pipeline registers. It adds the following over a logic-only execute stage:
- logic, shift, arithmetic, compare and HI/LO move operations;
- single-cycle multiply;
- an iterative signed/unsigned divider that stalls the pipeline while it runs.

Results and HI/LO write requests go to EX/MEM; stall requests go to the pipeline control block.

## Interface
- DATA_W, 32, datapath width in bits; even, ≥ 8.
- CNT_W, $clog2(DATA_W)+1, divider counter width (derived; do not override).

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset (`RstEnable`).
- aluop_i  in  `AluOpBus`  operation code.
- alusel_i  in  `AluSelBus`  result class (`EXE_RES_LOGIC`, `_SHIFT`, `_ARITH`, `_MOVE`, `_MUL`, `_NOP`).
- reg1_i, reg2_i  in  DATA_W  operands; shifts use reg1_i[$clog2(DATA_W)-1:0] as amount, reg2_i as value.
- wd_i  in  `RegAddrBus`  destination register.
- wreg_i  in  1  destination write enable.
- hi_i, lo_i  in  DATA_W  current (forwarded) HI/LO.
- flush_i  in  1  pipeline flush; aborts a divide in progress.
- wd_o  out  `RegAddrBus`  = wd_i.
- wreg_o  out  1  = wreg_i.
- wdata_o  out  DATA_W  GPR result.
- whilo_o  out  1  HI/LO write request.
- hi_o, lo_o  out  DATA_W  HI/LO write data.
- stallreq_o  out  1  request to freeze IF/ID/EX.

## Operation
- Combinational ops, evaluated in the same cycle:
  - AND, OR, XOR, NOR
  - SLL, SRL, SRA (arithmetic fill from value MSB)
  - ADDU, SUBU (mod 2^DATA_W, no overflow trap)
  - SLT (signed) / SLTU: 1 or 0, zero-extended
  - MFHI/MFLO: wdata_o = hi_i/lo_i
  - MTHI: whilo_o=1, hi_o=reg1_i, lo_o=lo_i
  - MTLO: whilo_o=1, lo_o=reg1_i, hi_o=hi_i
- MULT/MULTU: full 2·DATA_W product in one cycle; {hi_o,lo_o} = product, whilo_o=1.
- wdata_o is selected by alusel_i. Unknown aluop or alusel gives wdata_o=0. whilo_o=0 except for MT*, MULT*, DIV*.
- DIV/DIVU use an FSM with states IDLE, DIVZERO, BUSY, DONE.
  - IDLE: on a DIV/DIVU op, go to DIVZERO if reg2_i==0, else to BUSY. For DIV, latch |reg1_i|, |reg2_i| and the sign flags; clear the counter.
  - BUSY: restoring shift-subtract, one quotient bit per cycle. After DATA_W iterations go to DONE.
  - DIVZERO: go to DONE with quotient=0, remainder=0.
  - DONE: for DIV, negate the quotient if the operand signs differ; the remainder takes the dividend's sign. Output lo_o=quotient, hi_o=remainder, whilo_o=1. Return to IDLE.
- stallreq_o=1 whenever a DIV* op is presented and state≠DONE. stallreq_o=0 in DONE.
- Upstream holds all inputs stable while stallreq_o=1.
- flush_i=1 in any state gives next state IDLE, and stallreq_o=0 and whilo_o=0 that cycle.
- rst=1 gives next state IDLE and counter 0. While rst=1 all outputs are forced to 0.

## Timing
- Non-divide ops: zero-cycle combinational path input→output; no internal state touched.
- Nonzero divide presented in cycle 0:
  - stallreq_o=1 in cycles 0…DATA_W; BUSY occupies cycles 1…DATA_W.
  - DONE in cycle DATA_W+1: stallreq_o=0, whilo_o=1.
  - The instruction occupies DATA_W+2 cycles (34 at 32-bit).
- Divide by zero: stall in cycle 0 (IDLE) and cycle 1 (DIVZERO); DONE in cycle 2. 3 cycles total.
- DONE always returns to IDLE. A back-to-back divide starts fresh in the following cycle.
- Reset asserted mid-divide: IDLE on the next edge; partial result discarded, no HI/LO write.

## Test plan
- OR 0xF0F0_0000 | 0x0000_0F0F → wdata_o=0xF0F0_0F0F, wreg_o/wd_o pass through, whilo_o=0, stallreq_o=0.
- SRA value 0x8000_0000 by 4 → 0xF800_0000. SLT with reg1_i=0xFFFF_FFFF, reg2_i=1 → 1. SLTU with the same operands → 0.
- MULT 0xFFFF_FFFE × 3 → hi_o=0xFFFF_FFFF, lo_o=0xFFFF_FFFA, whilo_o=1 same cycle.
- DIV −7 / 2 → stallreq_o high 33 cycles, then lo_o=0xFFFF_FFFD, hi_o=0xFFFF_FFFF, whilo_o=1 for 1 cycle. DIVU 7/2 → lo_o=3, hi_o=1.
- DIVU x/0 → stall 2 cycles, then hi_o=lo_o=0, whilo_o=1.
- Divide aborted at cycle 10 by flush_i, and separately by rst → no whilo_o pulse, stallreq_o=0 next cycle. A new DIVU 100/10 then gives lo_o=10, hi_o=0 after full latency.
